imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that receives a MIPS image over a UART serial line and writes it word by word into the processor's 4096-word instruction memory. It holds the processor in reset until the image has been written and its checksum has been verified. It sits between the board's UART RX pin and the instruction memory write port; the processor pipeline only reads that port.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clk cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- ADDR_WIDTH, default 12: word-address width of the instruction memory (4096 words).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rxd  in  1  UART receive line, asynchronous, idle high, 8N1 framing.
- mem_addr  out  ADDR_WIDTH  word address for the instruction memory write.
- mem_din  out  32  write data.
- mem_we  out  1  write strobe, one cycle per word.
- cpu_rst  out  1  processor reset; high until the load completes successfully.
- done  out  1  load complete, checksum OK; sticky.
- err  out  1  framing, length or checksum error; sticky.

## Operation
- Wire protocol: byte 0–1 = word count N (16-bit, little-endian), then N×4 payload bytes with each word little-endian, then 1 checksum byte equal to the XOR of all payload bytes. The header bytes are not included in the checksum.
- UART RX sub-block behaviour:
  - rxd passes through a 2-FF synchronizer.
  - A high→low transition on the synchronized line starts a frame.
  - At CLKS_PER_BIT/2 the line is re-sampled. If it is high, the event is a glitch and the receiver returns to idle with no byte and no error.
  - The 8 data bits are then sampled LSB first, one every CLKS_PER_BIT.
  - The stop bit is sampled after that. If it is high, the receiver emits a 1-cycle byte_valid. If it is low, it emits a 1-cycle frame_err and no byte.
- Loader FSM states: HDR0 → HDR1 → DATA → CSUM → DONE; any state can go to ERR.
  - HDR0 latches N[7:0]. HDR1 latches N[15:8].
  - After HDR1: if N > 2^ADDR_WIDTH, go to ERR. If N == 0, go to CSUM. Otherwise go to DATA.
  - DATA shifts each byte into bits [8k+7:8k], where k = byte index 0..3 within the word, and XORs the byte into the running checksum.
  - On the 4th byte of a word, mem_we is asserted with mem_addr = word index and mem_din = the assembled word. The word index then increments.
  - After word N−1 the FSM goes to CSUM.
  - CSUM: if the received byte equals the running XOR, go to DONE; otherwise go to ERR.
  - frame_err in any state before DONE sends the FSM to ERR.
- DONE and ERR are terminal until rst. All rxd activity in these states is ignored; no writes occur.
- cpu_rst = 1 in every state except DONE.
- Reset values: FSM in HDR0, mem_addr = 0, mem_din = 0, mem_we = 0, cpu_rst = 1, done = 0, err = 0, checksum = 0, word index = 0, byte index = 0.
- rst during an active load aborts it: state returns to HDR0, cpu_rst = 1, and any partially received UART frame is discarded.

## Timing
- rxd to synchronized line: 2 cycles.
- byte_valid is asserted at the stop-bit mid-sample, about 9.5 bit times after the start edge plus 2 cycles.
- mem_we is asserted in the cycle after the byte_valid of a word's 4th byte and is high for exactly 1 cycle. mem_addr and mem_din are registered and stable while mem_we is high.
- done and cpu_rst deassert together, 1 cycle after the checksum byte_valid. err is asserted 1 cycle after the offending event.
- Back-to-back frames, where the next start bit follows the stop bit immediately, must be received without loss.
- Word-index arithmetic is ADDR_WIDTH+1 bits wide so that N = 2^ADDR_WIDTH is accepted without wrap.

## Structure
- Sub-module: uart_rx, with parameter CLKS_PER_BIT, inputs clk, rst and rxd, and outputs byte_valid, data[7:0] and frame_err.
- Shared header LOADER.v (included like INST.v) holds the state encodings LD_HDR0 … LD_ERR and the protocol constants: header length 2 and bytes per word 4.
- Total RTL is about 200 lines.

## Test plan
- N=2 with words 0x20080005 and 0xAC080000, checksum 0x89 → mem_we pulses at addr 0 then addr 1 with those exact words; then done=1, cpu_rst=0, err=0.
- N=0, checksum 0x00 → no mem_we; done=1 about 3 frames after the start.
- N=1, word 0x12345678, checksum 0x00 (correct value 0x08) → one write to addr 0; then err=1, cpu_rst stays 1, done=0.
- Stop bit driven low on the 3rd payload byte → err=1, no mem_we for that word; later bytes are ignored.
- Low pulse of CLKS_PER_BIT/4 cycles on rxd, then a valid N=1 load → the glitch produces no byte and no error; the load completes normally.
- rst asserted mid-word during an N=4 load, then a full N=1 load → writes restart at addr 0, done=1; no writes occur from the aborted load after rst.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - loader/receiver state encodings and protocol constants
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LD_HDR0,
        LD_HDR1,
        LD_DATA,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Drops byte b into lane k of a little-endian word.
    function automatic logic [31:0] place_byte(input logic [31:0] word,
                                               input logic [1:0]  k,
                                               input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[{k, 3'b000} +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/imem_loader_uart_rx.sv
// rtl/imem_loader_uart_rx.sv - 8N1 UART receiver with start-bit glitch rejection
module uart_rx
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state;
    rx_state_t     state_next;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                // Line back high at mid start bit: treat as a glitch.
                if (cnt == HALF) begin
                    state_next = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL && bit_idx == 3'd7) begin
                    state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rxd;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                RX_START: begin
                    cnt <= (cnt == HALF) ? '0 : cnt + 1'b1;
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            data       <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART boot loader writing a checksummed image into instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic                  mem_we,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err
);

    localparam int IW = ADDR_WIDTH + 1;
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .byte_valid(rx_valid),
        .data      (rx_data),
        .frame_err (rx_ferr)
    );

    ld_state_t   state;
    ld_state_t   state_next;
    logic [15:0] n;
    logic [IW-1:0] word_idx;
    logic [1:0]  byte_idx;
    logic [31:0] word_buf;
    logic [7:0]  csum;
    logic [31:0] hdr_n;
    logic        word_end;
    logic        last_word;

    assign hdr_n     = {16'd0, rx_data, n[7:0]};
    assign word_end  = (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign last_word = ((32'(word_idx) + 32'd1) == {16'd0, n});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LD_HDR0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LD_HDR0: begin
                if (rx_ferr)       state_next = LD_ERR;
                else if (rx_valid) state_next = LD_HDR1;
            end
            LD_HDR1: begin
                if (rx_ferr) begin
                    state_next = LD_ERR;
                end else if (rx_valid) begin
                    if (hdr_n > MAX_WORDS)  state_next = LD_ERR;
                    else if (hdr_n == 32'd0) state_next = LD_CSUM;
                    else                     state_next = LD_DATA;
                end
            end
            LD_DATA: begin
                if (rx_ferr)                            state_next = LD_ERR;
                else if (rx_valid && word_end && last_word) state_next = LD_CSUM;
            end
            LD_CSUM: begin
                if (rx_ferr)       state_next = LD_ERR;
                else if (rx_valid) state_next = (rx_data == csum) ? LD_DONE : LD_ERR;
            end
            LD_DONE: state_next = LD_DONE;
            LD_ERR:  state_next = LD_ERR;
            default: state_next = LD_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n        <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word_buf <= '0;
            csum     <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                LD_HDR0: if (rx_valid) n[7:0]  <= rx_data;
                LD_HDR1: if (rx_valid) n[15:8] <= rx_data;
                LD_DATA: begin
                    if (rx_valid) begin
                        csum     <= csum ^ rx_data;
                        word_buf <= place_byte(word_buf, byte_idx, rx_data);
                        byte_idx <= byte_idx + 1'b1;
                        if (word_end) begin
                            mem_we   <= 1'b1;
                            mem_addr <= word_idx[ADDR_WIDTH-1:0];
                            mem_din  <= place_byte(word_buf, byte_idx, rx_data);
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done    = (state == LD_DONE);
    assign err     = (state == LD_ERR);
    assign cpu_rst = (state != LD_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with a byte-stream reference model
module tb_imem_loader;

    localparam int CPB = 16;
    localparam int AW  = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic          mem_we;
    logic          cpu_rst;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    imem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .mem_addr(mem_addr),
        .mem_din (mem_din),
        .mem_we  (mem_we),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  tx_bytes[$];
    bit          tx_bad[$];
    logic [31:0] words[$];
    logic        exp_done;
    logic        exp_err;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    wr_t         mon_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_din);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(mem_addr), mon_e.addr);
                check("write_data", mem_din, mon_e.data);
            end
        end
    end

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad, input int gap);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(!bad);
        rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Image from 'words': header, payload, then given or computed checksum.
    task automatic build(input bit use_given, input logic [7:0] given, input bit corrupt);
        logic [7:0] x;
        x = 8'h00;
        tx_bytes.delete();
        tx_bad.delete();
        tx_bytes.push_back(8'(words.size()));
        tx_bytes.push_back(8'(words.size() >> 8));
        foreach (words[w]) begin
            for (int k = 0; k < 4; k++) begin
                tx_bytes.push_back(words[w][8*k +: 8]);
                x = x ^ words[w][8*k +: 8];
            end
        end
        if (use_given)    tx_bytes.push_back(given);
        else if (corrupt) tx_bytes.push_back(x ^ 8'h5a);
        else              tx_bytes.push_back(x);
        foreach (tx_bytes[i]) tx_bad.push_back(1'b0);
    endtask

    // Reference: parse the byte stream up to the first bad frame.
    task automatic model();
        int len;
        int eff;
        int n;
        int ci;
        logic [7:0] x;
        len = tx_bytes.size();
        eff = len;
        x = 8'h00;
        for (int i = 0; i < len; i++) begin
            if (tx_bad[i]) begin
                eff = i;
                break;
            end
        end
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (eff < 2) begin
            exp_err = (eff < len);
            return;
        end
        n = int'(tx_bytes[0]) + 256 * int'(tx_bytes[1]);
        if (n > (1 << AW)) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            if (2 + 4*w + 3 < eff)
                exp_q.push_back('{w, {tx_bytes[2+4*w+3], tx_bytes[2+4*w+2],
                                      tx_bytes[2+4*w+1], tx_bytes[2+4*w]}});
        end
        ci = 2 + 4*n;
        if (ci < eff) begin
            for (int i = 2; i < ci; i++) x = x ^ tx_bytes[i];
            exp_done = (tx_bytes[ci] == x);
            exp_err  = !exp_done;
        end else begin
            exp_err = (eff < len);
        end
    endtask

    task automatic run_load(input string tag, input bit do_reset, input bit glitch, input bit rand_gap);
        if (do_reset) begin
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
        end
        repeat (2*CPB) @(negedge clk);
        if (glitch) begin
            rxd = 1'b0;
            repeat (CPB/4) @(negedge clk);
            rxd = 1'b1;
            repeat (3*CPB) @(negedge clk);
        end
        model();
        foreach (tx_bytes[i])
            send_byte(tx_bytes[i], tx_bad[i], rand_gap ? int'($urandom_range(0, 2*CPB)) : 0);
        repeat (4*CPB) @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_cpu_rst", 32'(cpu_rst), 1);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;

        words = '{32'h2008_0005, 32'hAC08_0000};
        build(1'b1, 8'h89, 1'b0);
        run_load("two_words", 1'b1, 1'b0, 1'b0);

        words.delete();
        build(1'b1, 8'h00, 1'b0);
        run_load("zero_words", 1'b1, 1'b0, 1'b0);

        words = '{32'h1234_5678};
        build(1'b1, 8'h00, 1'b0);
        run_load("bad_csum", 1'b1, 1'b0, 1'b0);

        words = '{$urandom()};
        build(1'b0, 8'h00, 1'b0);
        tx_bad[4] = 1'b1;
        run_load("bad_stop", 1'b1, 1'b0, 1'b0);

        words = '{$urandom()};
        build(1'b0, 8'h00, 1'b0);
        run_load("glitch", 1'b1, 1'b1, 1'b0);

        tx_bytes = '{8'h01, 8'h10, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h00};
        tx_bad   = '{0, 0, 0, 0, 0, 0, 0};
        run_load("too_long", 1'b1, 1'b0, 1'b0);

        // Abort mid-word: only the first complete word may be written.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2*CPB) @(negedge clk);
        words = '{$urandom(), $urandom(), $urandom(), $urandom()};
        build(1'b0, 8'h00, 1'b0);
        exp_q.push_back('{0, words[0]});
        for (int i = 0; i < 8; i++) send_byte(tx_bytes[i], 1'b0, 0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(tx_bytes[8][i]);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_cpu_rst", 32'(cpu_rst), 1);
        check("abort_done", 32'(done), 0);
        check("abort_first_word", exp_q.size(), 0);
        rst = 1'b0;
        rxd = 1'b1;
        exp_q.delete();
        words = '{$urandom()};
        build(1'b0, 8'h00, 1'b0);
        run_load("after_abort", 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            words.delete();
            for (int w = 0; w < int'($urandom_range(1, 5)); w++) words.push_back($urandom());
            build(1'b0, 8'h00, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) tx_bad[$urandom_range(0, tx_bytes.size() - 1)] = 1'b1;
            run_load("random", 1'b1, 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
